// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// Takes one load/store at a time, waits LATENCY cycles, performs the access
// on a byte-enabled word RAM and returns data or an ack.
// Misaligned and out-of-range accesses are flagged through rsp_err.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap_we_q, cap_we_d;
  logic [31:0] cap_addr_q, cap_addr_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic [3:0]  cap_be_q, cap_be_d;

  logic [31:0]           mem [0:DEPTH-1];
  logic [31:0]           ram_dout;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           be_mask;
  logic                  accept;
  logic                  go_resp;
  logic                  lanes_ok;
  logic                  range_ok;
  logic                  acc_err;
  logic                  ram_we;

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign word_idx = cap_addr_q[ADDR_WIDTH+1:2];

  // The access fires on the edge that moves WAIT into RESP. A LATENCY of 1
  // still passes through WAIT with a zero count so that rsp_valid always
  // rises exactly LATENCY edges after the accept edge.
  assign go_resp  = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // Byte-enable / alignment legality of the captured request
  always_comb begin
    lanes_ok = 1'b0;
    case (cap_be_q)
      4'b0001: lanes_ok = (cap_addr_q[1:0] == 2'd0);
      4'b0010: lanes_ok = (cap_addr_q[1:0] == 2'd1);
      4'b0100: lanes_ok = (cap_addr_q[1:0] == 2'd2);
      4'b1000: lanes_ok = (cap_addr_q[1:0] == 2'd3);
      4'b0011: lanes_ok = (cap_addr_q[1:0] == 2'd0);
      4'b1100: lanes_ok = (cap_addr_q[1:0] == 2'd2);
      4'b1111: lanes_ok = (cap_addr_q[1:0] == 2'd0);
      default: lanes_ok = 1'b0;
    endcase
  end

  assign range_ok = ((cap_addr_q >> (ADDR_WIDTH + 2)) == 32'd0);
  assign acc_err  = !(lanes_ok && range_ok);
  assign ram_we   = go_resp && cap_we_q && !acc_err;

  // Expand byte enables into a bit mask for load data
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign be_mask[8*gi +: 8] = {8{cap_be_q[gi]}};
  end

  // Next-state, latency counter and request capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_be_d    = cap_be_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_WAIT;
          cnt_d       = LAT_M1;
          cap_we_d    = req_we;
          cap_addr_d  = req_addr;
          cap_wdata_d = req_wdata;
          cap_be_d    = req_be;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers; reset aborts any held request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= 32'd0;
      cap_wdata_q <= 32'd0;
      cap_be_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_be_q    <= cap_be_d;
    end
  end

  // Word RAM: lane-masked write and registered read on the access edge
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (cap_be_q[k]) begin
          mem[word_idx][8*k +: 8] <= cap_wdata_q[8*k +: 8];
        end
      end
    end
    if (go_resp) begin
      ram_dout <= mem[word_idx];
    end
  end

  // Response outputs are zero outside RESP; data only for good loads
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) && acc_err;
    rsp_rdata = 32'd0;
    if ((state_q == S_RESP) && !cap_we_q && !acc_err) begin
      rsp_rdata = ram_dout & be_mask;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases with literal expectations,
// a transaction-level reference model compared every cycle, random traffic,
// and latency/spacing checks on LATENCY=1 and LATENCY=15 instances.
module tb_dmem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int gen_done = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] mm [0:(1<<AW)-1];
  bit          m_pend;
  int          m_age;
  logic        m_we;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [3:0]  m_be;
  bit          m_er;

  function automatic bit m_bad(input logic [31:0] a, input logic [3:0] be);
    logic [1:0] o;
    bit ok;
    o  = a[1:0];
    ok = (be == (4'b0001 << o)) || (!o[0] && be == (4'b0011 << o)) ||
         (o == 2'd0 && be == 4'b1111);
    return !ok || (a >= (32'd1 << (AW + 2)));
  endfunction

  function automatic logic [31:0] m_mask(input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0;
      m_age  = 0;
    end else if (m_pend) begin
      if (m_age >= LAT && rsp_ready) begin
        m_pend = 1'b0;
      end else if (m_age < LAT) begin
        m_age++;
        if (m_age == LAT) begin
          m_er = m_bad(m_addr, m_be);
          m_rd = 32'd0;
          if (!m_er && m_we)
            mm[m_addr[AW+1:2]] = (mm[m_addr[AW+1:2]] & ~m_mask(m_be)) | (m_wd & m_mask(m_be));
          else if (!m_er)
            m_rd = mm[m_addr[AW+1:2]] & m_mask(m_be);
        end
      end
    end else if (req_valid) begin
      m_pend = 1'b1;
      m_age  = 0;
      m_we   = req_we;
      m_addr = req_addr;
      m_wd   = req_wdata;
      m_be   = req_be;
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      bit ev;
      ev = m_pend && (m_age >= LAT);
      chk("req_ready", {31'd0, req_ready}, {31'd0, !m_pend});
      chk("busy",      {31'd0, busy},      {31'd0, m_pend});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
      chk("rsp_rdata", rsp_rdata, ev ? m_rd : 32'd0);
      chk("rsp_err",   {31'd0, rsp_err},   {31'd0, ev && m_er});
    end
  end

  // One request/response; called at posedge+1 with the DUT idle
  task automatic txn(input string nm, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rd, input logic exp_er, input bit pin);
    int lat;
    logic [31:0] rd;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    if (pin) begin
      chk({nm, "_lat"}, lat, LAT);
      chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, exp_er});
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_hold_rdata"}, rsp_rdata, exp_rd);
      chk({nm, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, "_ready_after_hs"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_valid_after_hs"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata,          32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Preload the words used by random traffic
    for (int i = 0; i < 16; i++) txn("pre", 1'b1, 32'(i * 4), $urandom, 4'hF, 0, 32'd0, 1'b0, 1'b0);

    // Store/load basics and lane handling
    txn("t1_st",  1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'd0,        1'b0, 1'b1);
    txn("t1_ld",  1'b0, 32'h10, 32'd0,        4'b1111, 0, 32'hDEADBEEF, 1'b0, 1'b1);
    txn("t2_st",  1'b1, 32'h11, 32'h0000AA00, 4'b0010, 0, 32'd0,        1'b0, 1'b1);
    txn("t2_ldw", 1'b0, 32'h10, 32'd0,        4'b1111, 0, 32'hDEADAAEF, 1'b0, 1'b1);
    txn("t2_ldh", 1'b0, 32'h12, 32'd0,        4'b1100, 0, 32'hDEAD0000, 1'b0, 1'b1);
    txn("t2_ldb", 1'b0, 32'h13, 32'd0,        4'b1000, 0, 32'hDE000000, 1'b0, 1'b1);
    // Error cases leave memory untouched
    txn("t3_mis", 1'b1, 32'h13,   32'hFFFFFFFF, 4'b0011, 0, 32'd0, 1'b1, 1'b1);
    txn("t3_be0", 1'b1, 32'h10,   32'hFFFFFFFF, 4'b0000, 0, 32'd0, 1'b1, 1'b1);
    txn("t3_oor", 1'b0, 32'h1000, 32'd0,        4'b1111, 0, 32'd0, 1'b1, 1'b1);
    txn("t3_chk", 1'b0, 32'h10,   32'd0,        4'b1111, 0, 32'hDEADAAEF, 1'b0, 1'b1);
    // Backpressure
    txn("t4_bp",  1'b0, 32'h10,   32'd0,        4'b1111, 5, 32'hDEADAAEF, 1'b0, 1'b1);

    // Reset in the middle of a store's wait
    txn("t6_pre", 1'b1, 32'h20, 32'h12345678, 4'b1111, 0, 32'd0, 1'b0, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_rst_busy",      {31'd0, busy},      32'd0);
    chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;
    txn("t6_ld", 1'b0, 32'h20, 32'd0, 4'b1111, 0, 32'h12345678, 1'b0, 1'b1);

    // Random traffic; request fields change every cycle, even while busy
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [1:0] a;
      @(posedge clk); #1;
      a = 2'($urandom);
      r = $urandom_range(0, 5);
      case (r)
        0, 1:    req_be = 4'b0001 << a;
        2:       req_be = 4'b0011 << a;
        3:       req_be = 4'b1111;
        default: req_be = 4'($urandom);
      endcase
      req_valid = ($urandom_range(0, 2) != 0);
      req_we    = 1'($urandom);
      req_addr  = {26'd0, 4'($urandom), a};
      if ($urandom_range(0, 9) == 0) req_addr = req_addr | (32'd1 << $urandom_range(12, 31));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("drain_idle", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 400 && gen_done < 2; i++) @(posedge clk);
    chk("lat_instances_done", gen_done, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- LATENCY=1 and LATENCY=15 instances ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int L = (gi == 0) ? 1 : 15;
    logic        x_rst, x_vld, x_rdy, x_we, x_rv, x_rr, x_err, x_busy;
    logic [31:0] x_addr, x_wd, x_rd;
    logic [3:0]  x_be;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(L)) u_dut (
      .clk(clk), .rst(x_rst),
      .req_valid(x_vld), .req_ready(x_rdy), .req_we(x_we),
      .req_addr(x_addr), .req_wdata(x_wd), .req_be(x_be),
      .rsp_valid(x_rv), .rsp_ready(x_rr), .rsp_rdata(x_rd),
      .rsp_err(x_err), .busy(x_busy)
    );

    initial begin
      int n, got;
      logic [31:0] val;
      time ta [2];
      x_rst = 1'b1; x_vld = 1'b0; x_we = 1'b0; x_addr = 32'd0; x_wd = 32'd0;
      x_be = 4'd0; x_rr = 1'b1;
      repeat (3) @(posedge clk);
      #1 x_rst = 1'b0;
      val = $urandom;
      for (int t = 0; t < 2; t++) begin
        x_vld = 1'b1; x_we = (t == 0); x_addr = 32'h40; x_wd = val; x_be = 4'hF;
        @(posedge clk); #1;
        x_vld = 1'b0;
        n = 0;
        while (!x_rv && n < 40) begin
          @(posedge clk); #1;
          n++;
        end
        chk($sformatf("L%0d_lat_t%0d", L, t), n, L);
        chk($sformatf("L%0d_rdata_t%0d", L, t), x_rd, (t == 0) ? 32'd0 : val);
        @(posedge clk); #1;
      end
      // Back-to-back loads with request held and responses taken at once
      x_vld = 1'b1; x_we = 1'b0;
      got = 0;
      for (int k = 0; k < 80 && got < 2; k++) begin
        bit s;
        s = x_rdy;
        @(posedge clk);
        if (s) begin
          ta[got] = $time;
          got++;
        end
        #1;
      end
      x_vld = 1'b0;
      chk($sformatf("L%0d_b2b_accepts", L), got, 2);
      if (got == 2) chk($sformatf("L%0d_b2b_spacing", L), 32'((ta[1] - ta[0]) / 10), L + 2);
      gen_done++;
    end
  end

endmodule
